elevator_call_panel: RTL
========================

Name: elevator_call_panel

Overview:
- Request-side initiator that feeds the serial `in` line of the elevator controller and consumes its red/green lamp outputs as busy and acknowledge.
- Latches hall/car button presses into a pending set and picks one floor round-robin.
- Sends the floor as a framed serial request, then waits for green (served) or a timeout.

Parameters:
FLOORS, 4, number of floors/buttons (2..16)
FLOOR_W, 2, floor index width, equals ceil(log2(FLOORS))
ACK_TIMEOUT, 16, WAIT_ACK cycles (counted only while r_in=0) before giving up

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
btn  input  FLOORS  raw button levels, one per floor, already synchronised
r_in  input  1  controller red lamp; 1 = controller busy/moving
g_in  input  1  controller green lamp; 1 = current request served
in_out  output  1  serial request line to controller `in`
pending  output  FLOORS  latched, not-yet-served requests
cur_floor  output  FLOOR_W  last floor acknowledged as served
busy  output  1  1 whenever FSM not in IDLE
served  output  1  one-cycle pulse on acknowledge
timeout  output  1  one-cycle pulse on ack timeout

Behaviour:
- Reset, at the clk edge with reset=1:
  - Values: in_out=0, pending=0, cur_floor=0, busy=0, served=0, timeout=0.
  - State: FSM state=IDLE, ack counter=0, btn_q=0, last_sel=FLOORS-1.
  - Reset asserted mid-frame aborts the frame; in_out is 0 from the next cycle.
- Button capture:
  - btn_q registers btn each cycle.
  - A rising edge (btn & ~btn_q) sets the pending bit at the next edge.
  - Held buttons do not re-trigger.
  - Several edges in one cycle all latch.
- Selection in IDLE, when pending!=0 and r_in=0:
  - sel = first set bit searching last_sel+1, last_sel+2, … modulo FLOORS.
  - Latch sel, set last_sel=sel, go to START.
  - If r_in=1, stay in IDLE; pending keeps accumulating.
- Frame, all registered; in_out valid in the cycle the FSM occupies the state:
  - START, 1 cycle: in_out=1.
  - DATA, FLOOR_W cycles: in_out = sel bits, MSB first.
  - STOP, 1 cycle: in_out=0.
  - Frame length is FLOOR_W+2 cycles (4 at default). r_in is ignored during the frame.
- WAIT_ACK (in_out=0):
  - g_in=1: clear pending[sel], cur_floor<=sel, served=1 for 1 cycle, go to IDLE. This has priority over timeout in the same cycle.
  - r_in=1 and g_in=0: ack counter holds.
  - r_in=0 and g_in=0: counter increments. When it reaches ACK_TIMEOUT-1, pulse timeout=1, keep pending[sel], go to IDLE, clear counter.
  - The counter clears on every entry to WAIT_ACK.
- Simultaneous button edge and served clear on the same floor: the set wins, and the bit stays pending.
- g_in outside WAIT_ACK is ignored.
- busy = (state != IDLE), registered with the state.
- Minimum spacing between frames: 1 IDLE cycle.

Test Plan:
- Reset behaviour: hold reset 2 cycles, then release with btn=0 -> all outputs 0, in_out stays 0 for 20 cycles.
- Single request: pulse btn[2] for 1 cycle, r_in=0.
  - pending=4'b0100 next cycle.
  - in_out sequence 1,1,0,0 (START, bits '10', STOP).
  - Raise g_in 3 cycles later -> served pulse, cur_floor=2, pending=0, busy=0.
- Round-robin: press btn[0] and btn[3] together with last_sel=3 after reset.
  - Floor 0 is framed first (in_out 1,0,0,0); ack it.
  - Floor 3 follows (in_out 1,1,1,0).
- Busy hold-off: r_in=1 with btn[1] pressed -> no frame while r_in=1. Drop r_in -> frame starts in the IDLE cycle after.
- Timeout: request floor 1 and never assert g_in, r_in=0.
  - timeout pulses exactly 16 cycles after entering WAIT_ACK; pending[1] stays 1; the frame re-sends.
  - Repeat with r_in=1 for 5 cycles inside WAIT_ACK -> timeout 5 cycles later.
- Reset mid-frame and set/clear collision:
  - Assert reset during DATA -> in_out=0 and pending=0 the next cycle.
  - New rising edge on btn[sel] in the same cycle as g_in -> served pulses, pending[sel] remains 1.

Source files
------------

// File: rtl/elevator_call_panel.sv
// elevator_call_panel: request-side initiator for the elevator controller.
// Captures button rising edges into a pending set, picks the next floor
// round-robin, shifts it out as a framed serial request on in_out, then
// waits for the controller's green lamp (served) or gives up after a
// bounded number of non-busy cycles (timeout).

// One floor's button capture: edge detect plus the sticky pending bit.
module elevator_call_slot (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic clr,
    output logic pend
);

    logic btn_q;

    // A new press sets the bit; an ack clears it, but a press in the same
    // cycle as the ack wins so the second request is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q <= 1'b0;
            pend  <= 1'b0;
        end else begin
            btn_q <= btn;
            pend  <= (btn & ~btn_q) | (pend & ~clr);
        end
    end

endmodule

module elevator_call_panel #(
    parameter int FLOORS      = 4,
    parameter int FLOOR_W     = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOORS-1:0]  btn,
    input  logic               r_in,
    input  logic               g_in,
    output logic               in_out,
    output logic [FLOORS-1:0]  pending,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic               busy,
    output logic               served,
    output logic               timeout
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_ACK
    } state_t;

    state_t             state;
    logic [FLOOR_W-1:0] sel;
    logic [FLOOR_W-1:0] last_sel;
    logic [FLOOR_W-1:0] shreg;
    logic [FLOOR_W-1:0] bit_cnt;
    logic [CNT_W-1:0]   ack_cnt;

    logic               ack_hit;
    logic [FLOORS-1:0]  clr_mask;
    logic [FLOOR_W-1:0] pick;
    logic               pick_found;

    // Green only counts while we are actually waiting for it.
    assign ack_hit = (state == WAIT_ACK) && g_in;

    genvar gi;
    generate
        for (gi = 0; gi < FLOORS; gi++) begin : g_slot
            assign clr_mask[gi] = ack_hit && (sel == FLOOR_W'(gi));

            elevator_call_slot u_slot (
                .clk   (clk),
                .reset (reset),
                .btn   (btn[gi]),
                .clr   (clr_mask[gi]),
                .pend  (pending[gi])
            );
        end
    endgenerate

    // Round-robin pick: first pending floor after the last one served,
    // wrapping modulo FLOORS, so the last served floor is checked last.
    always_comb begin
        int                 idx;
        logic [FLOOR_W-1:0] cand;
        pick       = '0;
        pick_found = 1'b0;
        idx        = 0;
        cand       = '0;
        for (int k = 1; k <= FLOORS; k++) begin
            idx = int'(last_sel) + k;
            if (idx >= FLOORS) idx = idx - FLOORS;
            cand = FLOOR_W'(idx);
            if (!pick_found && pending[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end
    end

    // Request FSM: frame = START(1) + floor MSB-first + STOP(0), then wait
    // for green or time out. All outputs are registered alongside state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= '0;
            last_sel  <= FLOOR_W'(FLOORS - 1);
            shreg     <= '0;
            bit_cnt   <= '0;
            ack_cnt   <= '0;
            in_out    <= 1'b0;
            cur_floor <= '0;
            busy      <= 1'b0;
            served    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            served  <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    in_out <= 1'b0;
                    // Controller busy holds us off; presses keep latching.
                    if (pick_found && !r_in) begin
                        sel      <= pick;
                        last_sel <= pick;
                        state    <= START;
                        busy     <= 1'b1;
                        in_out   <= 1'b1;
                    end
                end
                START: begin
                    state   <= DATA;
                    in_out  <= sel[FLOOR_W-1];
                    shreg   <= sel << 1;
                    bit_cnt <= FLOOR_W'(FLOOR_W - 1);
                end
                DATA: begin
                    if (bit_cnt == '0) begin
                        state  <= STOP;
                        in_out <= 1'b0;
                    end else begin
                        in_out  <= shreg[FLOOR_W-1];
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                STOP: begin
                    state   <= WAIT_ACK;
                    in_out  <= 1'b0;
                    ack_cnt <= '0;
                end
                WAIT_ACK: begin
                    in_out <= 1'b0;
                    if (g_in) begin
                        served    <= 1'b1;
                        cur_floor <= sel;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else if (!r_in) begin
                        // Only idle-lamp cycles count toward the timeout.
                        if (ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                            timeout <= 1'b1;
                            state   <= IDLE;
                            busy    <= 1'b0;
                            ack_cnt <= '0;
                        end else begin
                            ack_cnt <= ack_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    in_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
